// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension unit: extends an IN_W-bit immediate to OUT_W bits in
// one of four modes and queues results in a 2-entry FIFO with valid/ready on both sides.
module imm_extend_pipe #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  din,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout,
    output logic             neg
);

    typedef enum logic [1:0] {
        MODE_ZEXT   = 2'b00,
        MODE_SEXT   = 2'b01,
        MODE_BRANCH = 2'b10,
        MODE_UPPER  = 2'b11
    } ext_mode_e;

    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;

    logic [OUT_W-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Size casts avoid zero-width replications when IN_W == OUT_W.
    assign w_zext = OUT_W'(din);
    assign w_sext = OUT_W'($signed(din));

    always_comb begin
        w_ext = w_zext;
        case (ext_mode_e'(mode))
            MODE_ZEXT:   w_ext = w_zext;
            MODE_SEXT:   w_ext = w_sext;
            MODE_BRANCH: w_ext = w_sext << 1;
            MODE_UPPER:  w_ext = w_zext << (OUT_W - IN_W);
            default:     w_ext = w_zext;
        endcase
    end

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is cleared on reset because dout must read zero afterwards;
            // a plain data FIFO would normally leave its memory unreset.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_ext;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout = r_mem[r_rd_ptr];
    assign neg  = dout[OUT_W-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe at (5,8) and (8,8).
module tb_imm_extend_pipe;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_in_valid;
    logic       a_in_ready;
    logic [4:0] a_din;
    logic [1:0] a_mode;
    logic       a_out_valid;
    logic       a_out_ready;
    logic [7:0] a_dout;
    logic       a_neg;

    logic       b_in_valid;
    logic       b_in_ready;
    logic [7:0] b_din;
    logic [1:0] b_mode;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [7:0] b_dout;
    logic       b_neg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(5), .OUT_W(8)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .din       (a_din),
        .mode      (a_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .dout      (a_dout),
        .neg       (a_neg)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(8)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .din       (b_din),
        .mode      (b_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .dout      (b_dout),
        .neg       (b_neg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single accept on DUT A, then check the head one cycle later.
    task automatic push_a(input string tag, input logic [4:0] d, input logic [1:0] m,
                          input logic [7:0] exp_dout, input logic exp_neg);
        a_in_valid = 1'b1;
        a_din      = d;
        a_mode     = m;
        tick();
        a_in_valid = 1'b0;
        check({tag, ".valid"}, a_out_valid, 1);
        check({tag, ".dout"},  a_dout, exp_dout);
        check({tag, ".neg"},   a_neg, exp_neg);
    endtask

    task automatic push_b(input string tag, input logic [7:0] d, input logic [1:0] m,
                          input logic [7:0] exp_dout, input logic exp_neg);
        b_in_valid = 1'b1;
        b_din      = d;
        b_mode     = m;
        tick();
        b_in_valid = 1'b0;
        check({tag, ".valid"}, b_out_valid, 1);
        check({tag, ".dout"},  b_dout, exp_dout);
        check({tag, ".neg"},   b_neg, exp_neg);
    endtask

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_din       = '0;
        a_mode      = 2'b00;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_din       = '0;
        b_mode      = 2'b00;
        b_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst.out_valid", a_out_valid, 0);
        check("rst.in_ready",  a_in_ready, 1);
        check("rst.dout",      a_dout, 8'h00);
        check("rst.neg",       a_neg, 0);

        // Mode sweep, din = 10101
        push_a("m00", 5'b10101, 2'b00, 8'b00010101, 1'b0);
        push_a("m01", 5'b10101, 2'b01, 8'b11110101, 1'b1);
        push_a("m10", 5'b10101, 2'b10, 8'b11101010, 1'b1);
        push_a("m11", 5'b10101, 2'b11, 8'b10101000, 1'b1);

        // Positive values
        push_a("pos01", 5'b00100, 2'b01, 8'b00000100, 1'b0);
        push_a("pos10", 5'b01111, 2'b10, 8'b00011110, 1'b0);
        tick();
        check("drain.out_valid", a_out_valid, 0);

        // Backpressure: three back-to-back pushes with consumer stalled
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_mode      = 2'b00;
        a_din       = 5'h01;
        tick();
        check("bp1.dout", a_dout, 8'h01);
        check("bp1.in_ready", a_in_ready, 1);
        a_din = 5'h02;
        tick();
        check("bp2.in_ready", a_in_ready, 0);
        check("bp2.dout", a_dout, 8'h01);
        a_din = 5'h03;
        tick();
        check("bp3.in_ready", a_in_ready, 0);
        check("bp3.out_valid", a_out_valid, 1);
        check("bp3.dout_stable", a_dout, 8'h01);
        a_out_ready = 1'b1;
        tick();
        check("bp4.dout", a_dout, 8'h02);
        check("bp4.in_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        check("bp5.dout", a_dout, 8'h03);
        check("bp5.out_valid", a_out_valid, 1);
        tick();
        check("bp6.out_valid", a_out_valid, 0);

        // Streaming: count stays at 1 for 16 cycles
        a_in_valid = 1'b1;
        a_mode     = 2'b00;
        for (int i = 0; i < 16; i++) begin
            a_din = 5'(i);
            tick();
            check($sformatf("st%0d.dout", i), a_dout, 32'(i));
            check($sformatf("st%0d.in_ready", i), a_in_ready, 1);
            check($sformatf("st%0d.out_valid", i), a_out_valid, 1);
        end
        a_in_valid = 1'b0;
        tick();
        check("st.drain", a_out_valid, 0);

        // Reset with the buffer full
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_din       = 5'h0A;
        tick();
        a_din = 5'h0B;
        tick();
        a_in_valid = 1'b0;
        check("rm.full", a_in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm.out_valid", a_out_valid, 0);
        check("rm.in_ready",  a_in_ready, 1);
        check("rm.dout",      a_dout, 8'h00);
        check("rm.neg",       a_neg, 0);
        a_out_ready = 1'b1;
        push_a("rm.push", 5'b11111, 2'b01, 8'hFF, 1'b1);
        tick();
        check("rm.drain", a_out_valid, 0);

        // IN_W == OUT_W instance
        check("b.in_ready", b_in_ready, 1);
        push_b("b00", 8'h85, 2'b00, 8'h85, 1'b1);
        push_b("b01", 8'h85, 2'b01, 8'h85, 1'b1);
        push_b("b10", 8'h85, 2'b10, 8'h0A, 1'b0);
        push_b("b11", 8'h85, 2'b11, 8'h85, 1'b1);
        tick();
        check("b.drain", b_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
